// File: rtl/jtag_tap_pkg.sv
// Shared types and constants for the oversampled JTAG TAP responder.
package jtag_tap_pkg;

    // IEEE 1149.1 TAP controller states with their conventional 4-bit codes
    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR_SCAN   = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR_SCAN   = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_e;

    localparam int IR_W = 5;

    localparam logic [IR_W-1:0] IR_CAPTURE = 5'b00101;
    localparam logic [IR_W-1:0] IR_IDCODE  = 5'h01;
    localparam logic [IR_W-1:0] IR_CONFREG = 5'h06;
    localparam logic [IR_W-1:0] IR_BYPASS  = 5'h1F;

    // Next TAP state for one TCK rise with the given TMS
    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        tap_state_e n;
        case (s)
            TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   n = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          n = TEST_LOGIC_RESET;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_sampled_sync.sv
// Two-flop synchronizer for one asynchronous JTAG pin, with optional
// registered rise/fall detection on the synchronized value.
module jtag_pin_sync #(
    parameter logic RESET_VAL   = 1'b0,
    parameter bit   EDGE_DETECT = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic r_meta;
    logic r_sync;

    // Two-stage synchronizer; reset value matches the pin's idle level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= pin_i;
            r_sync <= r_meta;
        end
    end

    assign sync_o = r_sync;

    generate
        if (EDGE_DETECT) begin : g_edge
            logic r_prev;
            logic r_rise;
            logic r_fall;

            // Compare against the previous synchronized value; strobes are registered
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_prev <= RESET_VAL;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_prev <= r_sync;
                    r_rise <= r_sync & ~r_prev;
                    r_fall <= ~r_sync & r_prev;
                end
            end

            assign rise_o = r_rise;
            assign fall_o = r_fall;
        end else begin : g_no_edge
            assign rise_o = 1'b0;
            assign fall_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/jtag_tap_sampled.sv
// JTAG TAP responder with all pins oversampled in the clk_i domain.
// Supports IDCODE, a CONF_W-bit configuration register and BYPASS.
module jtag_tap_sampled
    import jtag_tap_pkg::*;
#(
    parameter logic [31:0]       IDCODE     = 32'h1000_0DB3,
    parameter int                CONF_W     = 9,
    parameter logic [CONF_W-1:0] CONF_RESET = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              jtag_tck_i,
    input  logic              jtag_trst_ni,
    input  logic              jtag_tms_i,
    input  logic              jtag_tdi_i,
    output logic              jtag_tdo_o,
    output logic              jtag_tdo_en_o,
    output logic [CONF_W-1:0] conf_o,
    output logic              conf_valid_o,
    output logic [3:0]        tap_state_o
);

    logic       w_tck_rise;
    logic       w_tck_fall;
    logic       w_tms;
    logic       w_tdi;
    logic       w_trst_n;
    logic [6:0] w_unused_sync;

    jtag_pin_sync #(.RESET_VAL(1'b0), .EDGE_DETECT(1'b1)) u_sync_tck (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .pin_i  (jtag_tck_i),
        .sync_o (w_unused_sync[0]),
        .rise_o (w_tck_rise),
        .fall_o (w_tck_fall)
    );

    jtag_pin_sync #(.RESET_VAL(1'b1), .EDGE_DETECT(1'b0)) u_sync_tms (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .pin_i  (jtag_tms_i),
        .sync_o (w_tms),
        .rise_o (w_unused_sync[1]),
        .fall_o (w_unused_sync[2])
    );

    jtag_pin_sync #(.RESET_VAL(1'b0), .EDGE_DETECT(1'b0)) u_sync_tdi (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .pin_i  (jtag_tdi_i),
        .sync_o (w_tdi),
        .rise_o (w_unused_sync[3]),
        .fall_o (w_unused_sync[4])
    );

    jtag_pin_sync #(.RESET_VAL(1'b1), .EDGE_DETECT(1'b0)) u_sync_trst (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .pin_i  (jtag_trst_ni),
        .sync_o (w_trst_n),
        .rise_o (w_unused_sync[5]),
        .fall_o (w_unused_sync[6])
    );

    tap_state_e        r_state;
    logic [IR_W-1:0]   r_ir;
    logic [IR_W-1:0]   r_ir_shift;
    logic [31:0]       r_dr_shift;
    logic [CONF_W-1:0] r_conf;
    logic              r_conf_valid;
    logic              r_tdo;
    logic              r_tdo_en;

    tap_state_e        w_state_next;
    logic [31:0]       w_dr_shifted;
    logic              w_in_shift;

    // Next TAP state from the synchronized TMS
    always_comb begin
        w_state_next = tap_next(r_state, w_tms);
    end

    // One DR shift step: TDI enters at the top bit of the selected register's length
    always_comb begin
        w_dr_shifted = {1'b0, r_dr_shift[31:1]};
        case (r_ir)
            IR_IDCODE:  w_dr_shifted[31]       = w_tdi;
            IR_CONFREG: w_dr_shifted[CONF_W-1] = w_tdi;
            default:    w_dr_shifted[0]        = w_tdi;
        endcase
    end

    assign w_in_shift = (r_state == SHIFT_DR) || (r_state == SHIFT_IR);

    // TAP controller, instruction/data registers and TDO, all stepped by TCK edges
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= TEST_LOGIC_RESET;
            r_ir         <= IR_IDCODE;
            r_ir_shift   <= '0;
            r_dr_shift   <= '0;
            r_conf       <= CONF_RESET;
            r_conf_valid <= 1'b0;
            r_tdo        <= 1'b0;
            r_tdo_en     <= 1'b0;
        end else begin
            r_conf_valid <= 1'b0;
            if (!w_trst_n) begin
                // TAP reset pin has priority over any TCK edge; conf is left alone
                r_state  <= TEST_LOGIC_RESET;
                r_ir     <= IR_IDCODE;
                r_tdo    <= 1'b0;
                r_tdo_en <= 1'b0;
            end else begin
                if (w_tck_rise) begin
                    r_state <= w_state_next;
                    case (r_state)
                        CAPTURE_IR: r_ir_shift <= IR_CAPTURE;
                        SHIFT_IR:   r_ir_shift <= {w_tdi, r_ir_shift[IR_W-1:1]};
                        UPDATE_IR:  r_ir       <= r_ir_shift;
                        CAPTURE_DR: begin
                            case (r_ir)
                                IR_IDCODE:  r_dr_shift <= IDCODE;
                                IR_CONFREG: r_dr_shift <= {{(32-CONF_W){1'b0}}, r_conf};
                                IR_BYPASS:  r_dr_shift <= '0;
                                default:    r_dr_shift <= '0;
                            endcase
                        end
                        SHIFT_DR:   r_dr_shift <= w_dr_shifted;
                        UPDATE_DR: begin
                            if (r_ir == IR_CONFREG) begin
                                r_conf       <= r_dr_shift[CONF_W-1:0];
                                r_conf_valid <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                    // Entering Test-Logic-Reset selects IDCODE
                    if (w_state_next == TEST_LOGIC_RESET) begin
                        r_ir <= IR_IDCODE;
                    end
                end
                if (w_tck_fall) begin
                    r_tdo_en <= w_in_shift;
                    if (r_state == SHIFT_IR) begin
                        r_tdo <= r_ir_shift[0];
                    end else if (r_state == SHIFT_DR) begin
                        r_tdo <= r_dr_shift[0];
                    end else begin
                        r_tdo <= 1'b0;
                    end
                end
            end
        end
    end

    assign jtag_tdo_o    = r_tdo;
    assign jtag_tdo_en_o = r_tdo_en;
    assign conf_o        = r_conf;
    assign conf_valid_o  = r_conf_valid;
    assign tap_state_o   = r_state;

endmodule
